// File: rtl/phase_search_seq_if.sv
// Control/status bundle between the phase-search sequencer and whoever drives it.
// Covers the config/start side, the core-facing side and the status/debug outputs.
interface phase_search_seq_if;
    // start is a one-cycle request honoured only when the sequencer is idle or failed;
    // abort is a level that wins over everything, so there is no ready/ack return path.
    logic       start;
    logic       abort;
    logic [7:0] cfg_div_ratio;
    logic [7:0] cfg_pre_bits;
    logic [7:0] cfg_min_pulses;
    logic       adc_pulse;
    logic       core_sync_locked;
    logic       core_enable;
    logic       core_preamble_end;
    logic [7:0] core_div_ratio;
    logic       busy;
    logic       locked;
    logic       lock_lost;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;

    modport master (
        output start, abort, cfg_div_ratio, cfg_pre_bits, cfg_min_pulses,
               adc_pulse, core_sync_locked,
        input  core_enable, core_preamble_end, core_div_ratio, busy, locked,
               lock_lost, fail, retry_cnt, state_dbg
    );

    modport slave (
        input  start, abort, cfg_div_ratio, cfg_pre_bits, cfg_min_pulses,
               adc_pulse, core_sync_locked,
        output core_enable, core_preamble_end, core_div_ratio, busy, locked,
               lock_lost, fail, retry_cnt, state_dbg
    );
endinterface

// File: rtl/phase_search_seq.sv
// Sequencer for the dynamic phase-search core: arms the core, times the preamble window,
// waits for lock, watches for lock loss and retries a bounded number of times.
module phase_search_seq #(
    parameter int ARM_CYC   = 2,
    parameter int DROP_CYC  = 2,
    parameter int LOCK_TO   = 64,
    parameter int LOSS_BITS = 8,
    parameter int MAX_RETRY = 3
) (
    input logic              clk_fast,
    input logic              rst_n,
    phase_search_seq_if.slave ctl
);
    localparam int CNT_MAX = (255 * LOSS_BITS > LOCK_TO) ? 255 * LOSS_BITS : LOCK_TO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_PRE   = 3'd2,
        S_WAIT  = 3'd3,
        S_TRACK = 3'd4,
        S_RETRY = 3'd5,
        S_FAIL  = 3'd6
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       bit_cnt;
    logic [7:0]       pulse_cnt;
    logic [7:0]       div_r, pre_r, min_r;
    logic [1:0]       retry_r;
    logic             enable_r, pe_r, busy_r, locked_r, lost_r, fail_r;
    logic             pe_next, lost_next;

    logic             start_ok;
    logic             wrap;
    logic             win_end;
    logic [7:0]       pulse_total;
    logic [CNT_W-1:0] wd_last;

    assign start_ok    = ctl.start && !ctl.abort && (state == S_IDLE || state == S_FAIL);
    assign wrap        = (cnt == CNT_W'(div_r) - CNT_W'(1));
    assign win_end     = (state == S_PRE) && wrap && (bit_cnt == pre_r - 8'd1);
    // The pulse arriving on the window's final cycle still counts toward the threshold.
    assign pulse_total = (ctl.adc_pulse && pulse_cnt != 8'hFF) ? pulse_cnt + 8'd1 : pulse_cnt;
    assign wd_last     = CNT_W'(div_r) * CNT_W'(LOSS_BITS) - CNT_W'(1);

    always_comb begin
        next_state = state;
        pe_next    = 1'b0;
        lost_next  = 1'b0;
        case (state)
            S_IDLE, S_FAIL: if (start_ok) next_state = S_ARM;
            S_ARM:   if (cnt == CNT_W'(ARM_CYC - 1)) next_state = S_PRE;
            S_PRE: begin
                if (win_end) begin
                    if (pulse_total >= min_r) begin
                        pe_next    = 1'b1;
                        next_state = S_WAIT;
                    end else begin
                        next_state = S_RETRY;
                    end
                end
            end
            S_WAIT: begin
                if (ctl.core_sync_locked)                next_state = S_TRACK;
                else if (cnt == CNT_W'(LOCK_TO - 1))     next_state = S_RETRY;
            end
            S_TRACK: begin
                if (!ctl.adc_pulse && cnt == wd_last) begin
                    lost_next  = 1'b1;
                    next_state = S_RETRY;
                end
                if (!ctl.core_sync_locked) next_state = S_RETRY;
            end
            S_RETRY: begin
                if (cnt == CNT_W'(DROP_CYC - 1))
                    next_state = (retry_r == 2'(MAX_RETRY)) ? S_FAIL : S_ARM;
            end
            default: next_state = S_IDLE;
        endcase
        if (ctl.abort) begin
            next_state = S_IDLE;
            pe_next    = 1'b0;
            lost_next  = 1'b0;
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            pulse_cnt <= '0;
            div_r     <= 8'd2;
            pre_r     <= 8'd1;
            min_r     <= '0;
            retry_r   <= '0;
            enable_r  <= 1'b0;
            pe_r      <= 1'b0;
            busy_r    <= 1'b0;
            locked_r  <= 1'b0;
            lost_r    <= 1'b0;
            fail_r    <= 1'b0;
        end else begin
            state <= next_state;

            // One shared counter: ARM/RETRY duration, PRE bit timing, WAIT timeout, TRACK watchdog.
            if (next_state != state)                        cnt <= '0;
            else if (state == S_PRE && wrap)                cnt <= '0;
            else if (state == S_TRACK && ctl.adc_pulse)     cnt <= '0;
            else if (state != S_IDLE && state != S_FAIL)    cnt <= cnt + CNT_W'(1);

            if (next_state != state)         bit_cnt <= '0;
            else if (state == S_PRE && wrap) bit_cnt <= bit_cnt + 8'd1;

            if (next_state != state)                        pulse_cnt <= '0;
            else if (state == S_PRE)                        pulse_cnt <= pulse_total;

            if (start_ok) begin
                div_r <= (ctl.cfg_div_ratio < 8'd2) ? 8'd2 : ctl.cfg_div_ratio;
                pre_r <= (ctl.cfg_pre_bits == 8'd0) ? 8'd1 : ctl.cfg_pre_bits;
                min_r <= ctl.cfg_min_pulses;
            end

            if (start_ok)
                retry_r <= '0;
            else if (next_state == S_RETRY && state != S_RETRY && retry_r != 2'd3)
                retry_r <= retry_r + 2'd1;

            enable_r <= (next_state == S_ARM) || (next_state == S_PRE) ||
                        (next_state == S_WAIT) || (next_state == S_TRACK);
            busy_r   <= (next_state != S_IDLE) && (next_state != S_FAIL);
            locked_r <= (next_state == S_TRACK);
            fail_r   <= (next_state == S_FAIL);
            pe_r     <= pe_next;
            lost_r   <= lost_next;
        end
    end

    assign ctl.core_enable       = enable_r;
    assign ctl.core_preamble_end = pe_r;
    assign ctl.core_div_ratio    = div_r;
    assign ctl.busy              = busy_r;
    assign ctl.locked            = locked_r;
    assign ctl.lock_lost         = lost_r;
    assign ctl.fail              = fail_r;
    assign ctl.retry_cnt         = retry_r;
    assign ctl.state_dbg         = state;
endmodule

// File: tb/tb_phase_search_seq.sv
// Directed bench for phase_search_seq: a table of preamble-window vectors plus hand-written
// sequences for lock, lock loss, retry/fail, timeout, abort and asynchronous reset.
module tb_phase_search_seq;
    logic clk;
    logic rst_n;
    phase_search_seq_if ctl ();

    phase_search_seq dut (
        .clk_fast (clk),
        .rst_n    (rst_n),
        .ctl      (ctl.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] div;
        logic [7:0] pre;
        logic [7:0] mn;
        int         per;
        int         exp_edge;
        logic       exp_pass;
        logic [7:0] exp_div;
    } vec_t;

    vec_t vecs [8];
    int   n_tests;
    int   n_fail;
    int   ev_edge, pe_edge, lost_edge, last_pulse, track_edge, retry_edge, en_bad, pe_cnt;
    logic ev_pass;
    int   ret_q [$];
    int   pe_q  [$];
    logic [2:0] prev_state;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        ctl.abort = 1'b1;
        step();
        ctl.abort = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] d, input logic [7:0] p, input logic [7:0] m);
        ctl.cfg_div_ratio  = d;
        ctl.cfg_pre_bits   = p;
        ctl.cfg_min_pulses = m;
        ctl.start          = 1'b1;
        step();
        ctl.start          = 1'b0;
    endtask

    // Pulse on the last cycle of every 'per'-cycle group, counted from the window opening (cycle 2).
    function automatic logic pulse_at(input int c, input int per);
        return (per != 0) && (c >= 2) && (((c - 2) % per) == per - 1);
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        ctl.start = 1'b0; ctl.abort = 1'b0;
        ctl.cfg_div_ratio = 8'd0; ctl.cfg_pre_bits = 8'd0; ctl.cfg_min_pulses = 8'd0;
        ctl.adc_pulse = 1'b0; ctl.core_sync_locked = 1'b0;

        // ---- reset values ----
        repeat (3) step();
        check("rst_outputs", {ctl.core_enable, ctl.core_preamble_end, ctl.busy, ctl.locked,
                              ctl.lock_lost, ctl.fail, ctl.retry_cnt, ctl.state_dbg}, 0);
        check("rst_div", ctl.core_div_ratio, 8'd2);
        #3 rst_n = 1'b1;
        step();
        check("idle_after_rst", ctl.state_dbg, 3'd0);

        // ---- table: window length, pulse threshold, config clamping ----
        vecs[0] = '{8'd8,   8'd16, 8'd4,   8, 130, 1'b1, 8'd8};
        vecs[1] = '{8'd4,   8'd4,  8'd4,   4, 18,  1'b1, 8'd4};
        vecs[2] = '{8'd4,   8'd4,  8'd5,   4, 18,  1'b0, 8'd4};
        vecs[3] = '{8'd0,   8'd0,  8'd0,   0, 4,   1'b1, 8'd2};
        vecs[4] = '{8'd1,   8'd3,  8'd1,   0, 8,   1'b0, 8'd2};
        vecs[5] = '{8'd3,   8'd5,  8'd5,   3, 17,  1'b1, 8'd3};
        vecs[6] = '{8'd3,   8'd5,  8'd6,   3, 17,  1'b0, 8'd3};
        vecs[7] = '{8'd255, 8'd2,  8'd255, 1, 512, 1'b1, 8'd255};
        for (int i = 0; i < 8; i++) begin
            go_idle();
            do_start(vecs[i].div, vecs[i].pre, vecs[i].mn);
            ev_edge = -1;
            ev_pass = 1'b0;
            for (int k = 1; k <= 600 && ev_edge < 0; k++) begin
                ctl.adc_pulse = pulse_at(k - 1, vecs[i].per);
                step();
                if (ctl.core_preamble_end) begin
                    ev_edge = k; ev_pass = 1'b1;
                end else if (ctl.state_dbg == 3'd5) begin
                    ev_edge = k; ev_pass = 1'b0;
                end
            end
            ctl.adc_pulse = 1'b0;
            check($sformatf("vec%0d_edge", i), ev_edge, vecs[i].exp_edge);
            check($sformatf("vec%0d_pass", i), ev_pass, vecs[i].exp_pass);
            check($sformatf("vec%0d_div", i), ctl.core_div_ratio, vecs[i].exp_div);
            check($sformatf("vec%0d_state", i), ctl.state_dbg, vecs[i].exp_pass ? 3'd3 : 3'd5);
            check($sformatf("vec%0d_retry", i), ctl.retry_cnt, vecs[i].exp_pass ? 2'd0 : 2'd1);
        end

        // ---- lock, steady tracking, then pulses stop -> lock_lost 64 edges later ----
        go_idle();
        do_start(8'd8, 8'd16, 8'd4);
        pe_edge = -1; lost_edge = -1; last_pulse = -1;
        for (int k = 1; k <= 400 && lost_edge < 0; k++) begin
            ctl.adc_pulse = (k - 1 < 200) && pulse_at(k - 1, 8);
            if (ctl.adc_pulse) last_pulse = k - 1;
            ctl.core_sync_locked = (pe_edge >= 0) && (k - 1 >= pe_edge + 3);
            step();
            if (ctl.core_preamble_end && pe_edge < 0) pe_edge = k;
            if (pe_edge >= 0 && k == pe_edge + 4) begin
                check("lock_locked", ctl.locked, 1'b1);
                check("lock_state", ctl.state_dbg, 3'd4);
                check("lock_retry", ctl.retry_cnt, 2'd0);
            end
            if (ctl.lock_lost) lost_edge = k;
        end
        ctl.adc_pulse = 1'b0;
        ctl.core_sync_locked = 1'b0;
        check("lock_pe_edge", pe_edge, 130);
        check("lost_edge", lost_edge, 258);      // last pulse in cycle 193, sampled at edge 194
        check("lost_state", ctl.state_dbg, 3'd5);
        check("lost_retry", ctl.retry_cnt, 2'd1);
        check("lost_enable", ctl.core_enable, 1'b0);
        step();
        check("lost_pulse_width", ctl.lock_lost, 1'b0);
        check("drop_enable", ctl.core_enable, 1'b0);
        step();
        check("rearm_state", ctl.state_dbg, 3'd1);
        check("rearm_enable", ctl.core_enable, 1'b1);

        // ---- no pulses: three retries then FAIL ----
        go_idle();
        do_start(8'd8, 8'd16, 8'd4);
        ret_q.delete();
        en_bad = 0; pe_cnt = 0; prev_state = 3'd1;
        for (int k = 1; k <= 396; k++) begin
            step();
            if (ctl.state_dbg == 3'd5 && prev_state != 3'd5) ret_q.push_back(k);
            if (ctl.state_dbg == 3'd5 && ctl.core_enable) en_bad++;
            if ((ctl.state_dbg == 3'd1 || ctl.state_dbg == 3'd2) && !ctl.core_enable) en_bad++;
            if (ctl.core_preamble_end) pe_cnt++;
            prev_state = ctl.state_dbg;
        end
        check("fail_retry_count", ret_q.size(), 3);
        if (ret_q.size() == 3) begin
            check("fail_retry0", ret_q[0], 130);
            check("fail_retry1", ret_q[1], 262);
            check("fail_retry2", ret_q[2], 394);
        end
        check("fail_enable_pattern", en_bad, 0);
        check("fail_no_pe", pe_cnt, 0);
        check("fail_state", ctl.state_dbg, 3'd6);
        check("fail_flag", ctl.fail, 1'b1);
        check("fail_retry_cnt", ctl.retry_cnt, 2'd3);
        check("fail_busy", ctl.busy, 1'b0);
        check("fail_enable", ctl.core_enable, 1'b0);
        do_start(8'd8, 8'd16, 8'd4);
        check("fail_restart_state", ctl.state_dbg, 3'd1);
        check("fail_restart_retry", ctl.retry_cnt, 2'd0);
        check("fail_restart_flag", ctl.fail, 1'b0);

        // ---- WAIT timeout, lock on the last WAIT cycle, watchdog pulse-wins ----
        go_idle();
        do_start(8'd2, 8'd1, 8'd0);
        pe_q.delete();
        retry_edge = -1; track_edge = -1; lost_edge = -1;
        for (int k = 1; k <= 300 && lost_edge < 0; k++) begin
            ctl.core_sync_locked = (pe_q.size() == 2) && (k - 1 >= pe_q[1] + 63);
            ctl.adc_pulse = (track_edge >= 0) && (k - 1 == track_edge + 15);
            step();
            if (ctl.core_preamble_end) pe_q.push_back(k);
            if (ctl.state_dbg == 3'd5 && retry_edge < 0) retry_edge = k;
            if (ctl.state_dbg == 3'd4 && track_edge < 0) track_edge = k;
            if (k == 67)  check("wait_last_cycle", ctl.state_dbg, 3'd3);
            if (k == 137) check("wait2_last_cycle", ctl.state_dbg, 3'd3);
            if (track_edge >= 0 && k == track_edge + 16) begin
                check("wd_pulse_wins_state", ctl.state_dbg, 3'd4);
                check("wd_pulse_wins_lost", ctl.lock_lost, 1'b0);
            end
            if (ctl.lock_lost) lost_edge = k;
        end
        ctl.adc_pulse = 1'b0;
        check("to_pe_count", pe_q.size(), 2);
        if (pe_q.size() == 2) begin
            check("to_pe0", pe_q[0], 4);
            check("to_pe1", pe_q[1], 74);
        end
        check("to_retry_edge", retry_edge, 68);
        check("to_track_edge", track_edge, 138);
        check("to_lost_edge", lost_edge, 170);
        check("to_retry_cnt", ctl.retry_cnt, 2'd2);
        ctl.core_sync_locked = 1'b0;

        // ---- abort in PRE; start and abort together ----
        go_idle();
        do_start(8'd8, 8'd16, 8'd4);
        repeat (10) step();
        check("abort_pre_state", ctl.state_dbg, 3'd2);
        ctl.abort = 1'b1;
        step();
        ctl.abort = 1'b0;
        check("abort_state", ctl.state_dbg, 3'd0);
        check("abort_enable", ctl.core_enable, 1'b0);
        check("abort_pe", ctl.core_preamble_end, 1'b0);
        check("abort_busy", ctl.busy, 1'b0);
        ctl.cfg_div_ratio = 8'd20;
        ctl.start = 1'b1;
        ctl.abort = 1'b1;
        step();
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        check("start_abort_state", ctl.state_dbg, 3'd0);
        check("start_abort_enable", ctl.core_enable, 1'b0);
        check("start_abort_div", ctl.core_div_ratio, 8'd8);
        step();
        check("start_abort_stays_idle", ctl.state_dbg, 3'd0);

        // ---- start while busy ignored; async reset mid-TRACK ----
        go_idle();
        do_start(8'd0, 8'd0, 8'd0);
        check("busy_arm_state", ctl.state_dbg, 3'd1);
        check("busy_arm_enable", ctl.core_enable, 1'b1);
        ctl.cfg_div_ratio = 8'd50;
        ctl.start = 1'b1;
        step();
        ctl.start = 1'b0;
        step();
        check("busy_start_state", ctl.state_dbg, 3'd2);
        check("busy_start_div", ctl.core_div_ratio, 8'd2);
        step();
        step();
        check("short_window_pe", ctl.core_preamble_end, 1'b1);
        ctl.core_sync_locked = 1'b1;
        step();
        check("short_track", ctl.locked, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {ctl.core_enable, ctl.core_preamble_end, ctl.busy, ctl.locked,
                                    ctl.lock_lost, ctl.fail, ctl.retry_cnt, ctl.state_dbg}, 0);
        check("async_rst_div", ctl.core_div_ratio, 8'd2);
        ctl.core_sync_locked = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check("post_rst_idle", ctl.state_dbg, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
